// File: rtl/dac_scan_pkg.sv
// Shared constants for the DAC scan controller: DAC commands, frame length
// and the scan FSM encoding.
package dac_scan_pkg;

  localparam int FRAME_LEN = 32;

  localparam logic [3:0] CMD_WRITE      = 4'b0000;
  localparam logic [3:0] CMD_UPDATE_ALL = 4'b0010;
  localparam logic [3:0] CMD_WRITE_UPD  = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_GAP    = 2'd3
  } scan_state_e;

  // 8 don't-care zeros, command, address, left-aligned data field
  function automatic logic [FRAME_LEN-1:0] pack_frame(input logic [3:0]  cmd,
                                                      input logic [3:0]  addr,
                                                      input logic [15:0] data);
    return {8'h00, cmd, addr, data};
  endfunction

endpackage

// File: rtl/dac_scan_if.sv
// Host-side bus of dac_scan: channel register writes plus status/readback.
interface dac_scan_if #(
  parameter int CH_W   = 2,
  parameter int DATA_W = 12
);
  import dac_scan_pkg::*;

  logic                 wr_en;
  logic [CH_W-1:0]      wr_ch;
  logic [DATA_W-1:0]    wr_data;
  logic                 sync_mode;
  logic                 wr_err;
  logic                 busy;
  logic                 frame_done;
  logic [FRAME_LEN-1:0] rx_data;

  modport master (
    output wr_en, wr_ch, wr_data, sync_mode,
    input  wr_err, busy, frame_done, rx_data
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, sync_mode,
    output wr_err, busy, frame_done, rx_data
  );

endinterface

// File: rtl/dac_spi_frame.sv
// One-shot 32-bit SPI frame engine: SCK idles low, MOSI moves after falling
// edges, MISO is sampled on rising edges, CS_n low for 64*CLK_DIV cycles.
module dac_spi_frame
  import dac_scan_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [FRAME_LEN-1:0] word_i,
  input  logic                 miso_i,
  output logic                 sck_o,
  output logic                 mosi_o,
  output logic                 cs_n_o,
  output logic                 done_o,
  output logic [FRAME_LEN-1:0] rx_o
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

  logic                 active_q, active_d;
  logic                 sck_q, sck_d;
  logic                 cs_n_q, cs_n_d;
  logic                 done_q, done_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [CNT_W-1:0]     fall_cnt_q, fall_cnt_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [FRAME_LEN-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_LEN-1:0] rx_q, rx_d;

  always_comb begin
    active_d   = active_q;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    done_d     = 1'b0;
    div_d      = div_q;
    fall_cnt_d = fall_cnt_q;
    shift_d    = shift_q;
    rx_shift_d = rx_shift_q;
    rx_d       = rx_q;
    if (load_i) begin
      active_d   = 1'b1;
      sck_d      = 1'b0;
      cs_n_d     = 1'b0;
      div_d      = DIV_RELOAD;
      fall_cnt_d = CNT_W'(FRAME_LEN - 1);
      shift_d    = word_i;
    end else if (active_q) begin
      if (div_q != '0) begin
        div_d = div_q - DIV_W'(1);
      end else begin
        div_d = DIV_RELOAD;
        if (!sck_q) begin
          sck_d      = 1'b1;
          rx_shift_d = {rx_shift_q[FRAME_LEN-2:0], miso_i};
        end else begin
          sck_d   = 1'b0;
          shift_d = {shift_q[FRAME_LEN-2:0], 1'b0};
          // the final falling edge closes the frame in the same cycle
          if (fall_cnt_q == '0) begin
            active_d = 1'b0;
            cs_n_d   = 1'b1;
            done_d   = 1'b1;
            rx_d     = rx_shift_q;
          end else begin
            fall_cnt_d = fall_cnt_q - CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      done_q     <= 1'b0;
      div_q      <= '0;
      fall_cnt_q <= '0;
      shift_q    <= '0;
      rx_shift_q <= '0;
      rx_q       <= '0;
    end else begin
      active_q   <= active_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      done_q     <= done_d;
      div_q      <= div_d;
      fall_cnt_q <= fall_cnt_d;
      shift_q    <= shift_d;
      rx_shift_q <= rx_shift_d;
      rx_q       <= rx_d;
    end
  end

  assign sck_o  = sck_q;
  assign mosi_o = shift_q[FRAME_LEN-1];
  assign cs_n_o = cs_n_q;
  assign done_o = done_q;
  assign rx_o   = rx_q;

endmodule

// File: rtl/dac_scan.sv
// Multi-channel DAC refresh controller: channel registers with dirty bits,
// round-robin arbitration and command selection feeding one SPI frame engine.
module dac_scan
  import dac_scan_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 12,
  parameter int CLK_DIV  = 2
) (
  input  logic     CLK50MHZ,
  input  logic     RST,
  dac_scan_if.slave host,
  output logic     SPI_SCK,
  output logic     DAC_CS,
  output logic     SPI_MOSI,
  output logic     DAC_CLR,
  input  logic     DAC_OUT
);

  // state  | meaning
  // IDLE   | nothing dirty, CS high
  // SELECT | pick next dirty channel, snapshot it, start the frame
  // SHIFT  | frame engine shifting, wait for its done pulse
  // GAP    | CS high for CLK_DIV cycles between frames

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DIV_W = $clog2(CLK_DIV + 1);

  scan_state_e          state_q, state_d;
  logic [CHANNELS-1:0]  dirty_q, dirty_d;
  logic [CH_W-1:0]      ptr_q, ptr_d;
  logic [DIV_W-1:0]     gap_q, gap_d;
  logic                 wr_err_q;
  logic [DATA_W-1:0]    regs_q [CHANNELS];

  logic [CHANNELS-1:0]  wr_hit;
  logic                 wr_legal;
  logic                 sel_found;
  logic [CH_W-1:0]      sel_ch;
  logic [CHANNELS-1:0]  sel_mask;
  logic [CHANNELS-1:0]  remaining;
  logic [DATA_W-1:0]    sel_code;
  logic [CH_W-1:0]      next_ptr;
  logic [3:0]           cmd;
  logic [FRAME_LEN-1:0] frame_word;
  logic                 load;
  logic                 spi_done;
  logic                 spi_cs_n;
  logic [FRAME_LEN-1:0] spi_rx;

  always_comb begin
    wr_hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_hit[c] = host.wr_en && (host.wr_ch == CH_W'(c));
    end
  end

  assign wr_legal = |wr_hit;

  // first dirty channel at or after the pointer, wrapping
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    sel_mask  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!sel_found && dirty_q[c] && (((int'(ptr_q) + k) % CHANNELS) == c)) begin
          sel_found   = 1'b1;
          sel_ch      = CH_W'(c);
          sel_mask[c] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_code = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sel_ch == CH_W'(c)) sel_code = regs_q[c];
    end
  end

  assign remaining  = dirty_q & ~sel_mask;
  assign next_ptr   = (32'(sel_ch) == 32'(CHANNELS - 1)) ? '0 : sel_ch + CH_W'(1);
  assign cmd        = !host.sync_mode ? CMD_WRITE_UPD :
                      (|remaining)    ? CMD_WRITE     : CMD_UPDATE_ALL;
  assign frame_word = pack_frame(cmd, 4'(sel_ch), 16'(sel_code) << (16 - DATA_W));

  always_comb begin
    state_d = state_q;
    dirty_d = dirty_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|dirty_q) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (sel_found) begin
          load    = 1'b1;
          dirty_d = remaining;
          ptr_d   = next_ptr;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (spi_done) begin
          state_d = ST_GAP;
          gap_d   = DIV_W'(CLK_DIV - 1);
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = (|dirty_q) ? ST_SELECT : ST_IDLE;
        else             gap_d   = gap_q - DIV_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // a write landing on the channel being selected keeps it dirty
    dirty_d = dirty_d | wr_hit;
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      dirty_q  <= '0;
      ptr_q    <= '0;
      gap_q    <= '0;
      wr_err_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) regs_q[c] <= '0;
    end else begin
      state_q  <= state_d;
      dirty_q  <= dirty_d;
      ptr_q    <= ptr_d;
      gap_q    <= gap_d;
      wr_err_q <= host.wr_en && !wr_legal;
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_hit[c]) regs_q[c] <= host.wr_data;
      end
    end
  end

  dac_spi_frame #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk    (CLK50MHZ),
    .rst_n  (RST),
    .load_i (load),
    .word_i (frame_word),
    .miso_i (DAC_OUT),
    .sck_o  (SPI_SCK),
    .mosi_o (SPI_MOSI),
    .cs_n_o (spi_cs_n),
    .done_o (spi_done),
    .rx_o   (spi_rx)
  );

  assign DAC_CS          = spi_cs_n;
  assign DAC_CLR         = RST;
  assign host.wr_err     = wr_err_q;
  assign host.busy       = (state_q != ST_IDLE) || (|dirty_q);
  assign host.frame_done = spi_done;
  assign host.rx_data    = spi_rx;

endmodule

// File: tb/tb_dac_scan.sv
// Directed bench for dac_scan: decodes SPI frames off the pins and compares
// them with hand-computed words; a second 5-channel/16-bit instance covers wr_err.
`timescale 1ns/1ps
module tb_dac_scan;
  import dac_scan_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic spi_sck, dac_cs, spi_mosi, dac_clr;
  logic dac_out = 1'b0;
  logic sck5, cs5, mosi5, clr5;
  logic dac_out5 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  dac_scan_if #(.CH_W(2), .DATA_W(12)) host ();
  dac_scan_if #(.CH_W(3), .DATA_W(16)) host5 ();

  dac_scan #(.CHANNELS(4), .DATA_W(12), .CLK_DIV(2)) u_dut (
    .CLK50MHZ (clk),
    .RST      (rst_n),
    .host     (host),
    .SPI_SCK  (spi_sck),
    .DAC_CS   (dac_cs),
    .SPI_MOSI (spi_mosi),
    .DAC_CLR  (dac_clr),
    .DAC_OUT  (dac_out)
  );

  dac_scan #(.CHANNELS(5), .DATA_W(16), .CLK_DIV(1)) u_dut5 (
    .CLK50MHZ (clk),
    .RST      (rst_n),
    .host     (host5),
    .SPI_SCK  (sck5),
    .DAC_CS   (cs5),
    .SPI_MOSI (mosi5),
    .DAC_CLR  (clr5),
    .DAC_OUT  (dac_out5)
  );

  // pin-level frame decoder and DAC_OUT pattern source, main instance
  logic [31:0] frames[$];
  logic [31:0] cur_frame = '0;
  logic [31:0] rx_pattern = 32'hDEADBEEF;
  logic [31:0] pat_sh;
  int bitcnt = 0, cs_cnt = 0, last_cs_len = 0, done_cnt = 0;
  logic prev_sck = 1'b0, prev_cs = 1'b1;

  always @(negedge clk) begin
    if (host.frame_done) done_cnt++;
    if (prev_cs && !dac_cs) begin
      bitcnt = 0;
      cs_cnt = 0;
    end
    if (!prev_cs && dac_cs) begin
      last_cs_len = cs_cnt;
      if (bitcnt == 32) frames.push_back(cur_frame);
    end
    if (!dac_cs) begin
      cs_cnt++;
      if (!prev_sck && spi_sck) begin
        cur_frame = {cur_frame[30:0], spi_mosi};
        bitcnt++;
      end
    end
    pat_sh  = rx_pattern << bitcnt;
    dac_out = (bitcnt < 32) ? pat_sh[31] : 1'b0;
    prev_sck = spi_sck;
    prev_cs  = dac_cs;
  end

  // decoder for the 5-channel instance
  logic [31:0] frame5 = '0, cur5 = '0;
  int bit5 = 0, cs5_cnt = 0, last_cs5_len = 0, done5 = 0, nframes5 = 0;
  logic prev_sck5 = 1'b0, prev_cs5 = 1'b1;

  always @(negedge clk) begin
    if (host5.frame_done) done5++;
    if (prev_cs5 && !cs5) begin
      bit5 = 0;
      cs5_cnt = 0;
    end
    if (!prev_cs5 && cs5) begin
      last_cs5_len = cs5_cnt;
      if (bit5 == 32) begin
        frame5 = cur5;
        nframes5++;
      end
    end
    if (!cs5) begin
      cs5_cnt++;
      if (!prev_sck5 && sck5) begin
        cur5 = {cur5[30:0], mosi5};
        bit5++;
      end
    end
    prev_sck5 = sck5;
    prev_cs5  = cs5;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr_drive(input logic [3:0] ch, input logic [15:0] data);
    @(negedge clk);
    host.wr_en   = 1'b1;
    host.wr_ch   = ch[1:0];
    host.wr_data = data[11:0];
  endtask

  task automatic wr_idle();
    @(negedge clk);
    host.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (host.busy && n < 3000);
    repeat (2) @(negedge clk);
    chk(tag, 32'(host.busy), 32'd0);
  endtask

  task automatic wait_cs_low(input string tag);
    int n = 0;
    while (dac_cs && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(dac_cs), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d0, edges, n, f0, e0;
    logic prev;

    rst_n = 1'b0;
    host.wr_en = 1'b0;  host.wr_ch = '0;  host.wr_data = '0;  host.sync_mode = 1'b0;
    host5.wr_en = 1'b0; host5.wr_ch = '0; host5.wr_data = '0; host5.sync_mode = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_cs",    32'(dac_cs),          32'd1);
    chk("rst_sck",   32'(spi_sck),         32'd0);
    chk("rst_mosi",  32'(spi_mosi),        32'd0);
    chk("rst_clr",   32'(dac_clr),         32'd0);
    chk("rst_busy",  32'(host.busy),       32'd0);
    chk("rst_done",  32'(host.frame_done), 32'd0);
    chk("rst_err",   32'(host.wr_err),     32'd0);
    chk("rst_rx",    host.rx_data,         32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("clr_high", 32'(dac_clr), 32'd1);

    // single write, latency, frame format, CS width, readback
    base = frames.size(); d0 = done_cnt;
    wr_drive(4'd2, 16'h0ABC);
    wr_idle();
    chk("lat_busy", 32'(host.busy), 32'd1);
    chk("lat_n0",   32'(dac_cs),    32'd1);
    @(negedge clk);
    chk("lat_n1",   32'(dac_cs),    32'd1);
    @(negedge clk);
    chk("lat_n2",   32'(dac_cs),    32'd0);
    wait_idle("t1_idle");
    chk("t1_nframes", 32'(frames.size() - base), 32'd1);
    if (frames.size() > base) chk("t1_frame", frames[base], 32'h0032ABC0);
    chk("t1_cs_len", 32'(last_cs_len),      32'd128);
    chk("t1_done",   32'(done_cnt - d0),    32'd1);
    chk("t1_rx",     host.rx_data,          32'hDEADBEEF);

    // round-robin order from a fresh pointer
    pulse_reset();
    base = frames.size();
    wr_drive(4'd0, 16'h0111);
    wr_drive(4'd3, 16'h0333);
    wr_drive(4'd1, 16'h0222);
    wr_idle();
    wait_idle("t2_idle");
    chk("t2_nframes", 32'(frames.size() - base), 32'd3);
    if (frames.size() >= base + 3) begin
      chk("t2_f0", frames[base],     32'h00301110);
      chk("t2_f1", frames[base + 1], 32'h00312220);
      chk("t2_f2", frames[base + 2], 32'h00333330);
    end

    // synchronous batch: only the last frame updates all channels
    host.sync_mode = 1'b1;
    base = frames.size();
    wr_drive(4'd0, 16'h0111);
    wr_drive(4'd3, 16'h0333);
    wr_drive(4'd1, 16'h0222);
    wr_idle();
    wait_idle("t3_idle");
    host.sync_mode = 1'b0;
    chk("t3_nframes", 32'(frames.size() - base), 32'd3);
    if (frames.size() >= base + 3) begin
      chk("t3_f0", frames[base],     32'h00001110);
      chk("t3_f1", frames[base + 1], 32'h00012220);
      chk("t3_f2", frames[base + 2], 32'h00233330);
    end

    // rewrite of the channel currently on the wire
    base = frames.size();
    wr_drive(4'd1, 16'h0444);
    wr_idle();
    wait_cs_low("t4_cs_low");
    repeat (10) @(negedge clk);
    wr_drive(4'd1, 16'h0555);
    wr_idle();
    wait_idle("t4_idle");
    chk("t4_nframes", 32'(frames.size() - base), 32'd2);
    if (frames.size() >= base + 2) begin
      chk("t4_f0", frames[base],     32'h00314440);
      chk("t4_f1", frames[base + 1], 32'h00315550);
    end

    // reset in the middle of a frame
    base = frames.size(); d0 = done_cnt;
    wr_drive(4'd0, 16'h0777);
    wr_drive(4'd2, 16'h0999);
    wr_idle();
    wait_cs_low("t5_cs_low");
    prev = spi_sck; edges = 0; n = 0;
    while (edges < 10 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (spi_sck !== prev) edges++;
      prev = spi_sck;
    end
    chk("t5_edges", 32'(edges), 32'd10);
    rst_n = 1'b0;
    #1;
    chk("t5_cs",   32'(dac_cs),    32'd1);
    chk("t5_sck",  32'(spi_sck),   32'd0);
    chk("t5_mosi", 32'(spi_mosi),  32'd0);
    chk("t5_clr",  32'(dac_clr),   32'd0);
    chk("t5_busy", 32'(host.busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("t5_nframes", 32'(frames.size() - base), 32'd0);
    chk("t5_done",    32'(done_cnt - d0),        32'd0);
    chk("t5_busy_after", 32'(host.busy),         32'd0);
    chk("t5_rx",      host.rx_data,              32'h0);

    // illegal channel on a 5-channel, 16-bit, CLK_DIV=1 instance
    f0 = nframes5; e0 = done5;
    @(negedge clk);
    host5.wr_en = 1'b1; host5.wr_ch = 3'd5; host5.wr_data = 16'h1234;
    @(negedge clk);
    chk("t6_err5",    32'(host5.wr_err), 32'd1);
    host5.wr_ch = 3'd7;
    @(negedge clk);
    chk("t6_err7",    32'(host5.wr_err), 32'd1);
    host5.wr_en = 1'b0;
    @(negedge clk);
    chk("t6_err_off", 32'(host5.wr_err), 32'd0);
    chk("t6_busy",    32'(host5.busy),   32'd0);
    repeat (100) @(negedge clk);
    chk("t6_nodone",  32'(done5 - e0),   32'd0);

    @(negedge clk);
    host5.wr_en = 1'b1; host5.wr_ch = 3'd4; host5.wr_data = 16'hBEEF;
    @(negedge clk);
    host5.wr_en = 1'b0;
    chk("t6_legal_err", 32'(host5.wr_err), 32'd0);
    n = 0;
    while (nframes5 == f0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t6_nframes", 32'(nframes5 - f0),     32'd1);
    chk("t6_frame",   frame5,                 32'h0034BEEF);
    chk("t6_cs_len",  32'(last_cs5_len),      32'd64);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
